// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO serializer.
// Build option PISO_PARITY_EN appends an even-parity bit to every frame.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

`ifdef PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int frame_len(input int width, input bit parity);
    return parity ? width + 1 : width;
  endfunction

  function automatic int cnt_width(input int flen);
    return (flen <= 2) ? 1 : $clog2(flen);
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Modulo-FRAME_LEN bit counter: clear restarts a frame at bit 0, enable
// advances and wraps; last flags the final bit of the frame.
module serial_bit_counter #(
  parameter int FRAME_LEN = 8,
  parameter int CW        = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          last
);

  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LAST_IDX) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == LAST_IDX);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage with gapless back-to-back frames.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             busy,
  output piso_state_e      state_dbg
);

  // Handshake: a word is taken on a rising edge where load_valid && load_ready;
  // load_ready is combinational and opens in IDLE or on the last frame bit.

  localparam int FRAME_LEN = frame_len(WIDTH, PARITY_EN);
  localparam int CW        = cnt_width(FRAME_LEN);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             serial_out_q, serial_out_d;
  logic             serial_valid_q, serial_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;

  logic [CW-1:0]    bit_cnt;
  logic             last_bit;
  logic             accept;
  logic             first_bit;
  logic [WIDTH-1:0] load_rest;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_next;
  logic             out_bit;

  // The register holds only the bits not yet on serial_out, aligned so the
  // next one always sits at the outgoing end.
  generate
    if (MSB_FIRST) begin : g_msb
      assign first_bit  = load_data[WIDTH-1];
      assign load_rest  = load_data << 1;
      assign next_bit   = shreg_q[WIDTH-1];
      assign shreg_next = shreg_q << 1;
    end else begin : g_lsb
      assign first_bit  = load_data[0];
      assign load_rest  = load_data >> 1;
      assign next_bit   = shreg_q[0];
      assign shreg_next = shreg_q >> 1;
    end
  endgenerate

  assign load_ready = !reset && ((state_q == IDLE) || (state_q == SHIFT && last_bit));
  assign accept     = load_valid && load_ready;

  serial_bit_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CW        (CW)
  ) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state_q == SHIFT),
    .count  (bit_cnt),
    .last   (last_bit)
  );

`ifdef PISO_PARITY_EN
  localparam logic [CW-1:0] DATA_LAST_IDX = CW'(WIDTH - 1);

  logic parity_q, parity_d;

  assign parity_d = accept ? ^load_data : parity_q;
  // Once the last data bit is out, the parity bit follows it.
  assign out_bit  = (bit_cnt == DATA_LAST_IDX) ? parity_q : next_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`else
  logic unused_bit_cnt;

  assign unused_bit_cnt = ^bit_cnt;
  assign out_bit        = next_bit;
`endif

  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    serial_out_d   = 1'b0;
    serial_valid_d = 1'b0;
    frame_start_d  = 1'b0;
    busy_d         = 1'b0;
    if (accept) begin
      state_d        = SHIFT;
      shreg_d        = load_rest;
      serial_out_d   = first_bit;
      serial_valid_d = 1'b1;
      frame_start_d  = 1'b1;
      busy_d         = 1'b1;
    end else if (state_q == SHIFT && !last_bit) begin
      shreg_d        = shreg_next;
      serial_out_d   = out_bit;
      serial_valid_d = 1'b1;
      busy_d         = 1'b1;
    end else if (state_q == SHIFT) begin
      state_d = IDLE;
      shreg_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      frame_start_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
      frame_start_q  <= frame_start_d;
      busy_q         <= busy_d;
    end
  end

  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign frame_start  = frame_start_q;
  assign busy         = busy_q;
  assign state_dbg    = state_q;

endmodule
